// File: rtl/snr_sweep_ctrl.sv
// SNR sweep controller: moves one stereo sample through the AWGN corruptor and owns the SNR level.
// Dwell-based auto-advance is built only when SNR_SWEEP_AUTO_EN is defined.
module snr_sweep_ctrl #(
   parameter int DATA_W        = 32,
   parameter int DWELL_SAMPLES = 48000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              audio_in_available,
   output logic              read_audio_in,
   input  logic [DATA_W-1:0] left_in,
   input  logic [DATA_W-1:0] right_in,
   input  logic              awgn_valid,
   input  logic [DATA_W-1:0] awgn,
   output logic              awgn_ready,
   output logic [2:0]        snr_code,
   output logic [DATA_W-1:0] corrupt_left,
   output logic [DATA_W-1:0] corrupt_right,
   output logic [DATA_W-1:0] corrupt_awgn,
   input  logic [DATA_W-1:0] noisy_left,
   input  logic [DATA_W-1:0] noisy_right,
   input  logic              audio_out_allowed,
   output logic              write_audio_out,
   output logic [DATA_W-1:0] left_out,
   output logic [DATA_W-1:0] right_out,
   input  logic              step_key,
   input  logic              auto_mode,
   output logic [2:0]        level_idx,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, POP, NOISE, SETTLE, PUSH} state_t;

   state_t     state;
   logic       key_q;
   logic       step_pend;
   logic       key_rise;
   logic       dwell_expired;
   logic       advance;
   logic [2:0] level_nxt;

   function automatic logic [2:0] level_code(input logic [2:0] idx);
      case (idx)
         3'd0:    level_code = 3'b010;
         3'd1:    level_code = 3'b001;
         3'd2:    level_code = 3'b011;
         3'd3:    level_code = 3'b111;
         3'd4:    level_code = 3'b110;
         3'd5:    level_code = 3'b100;
         3'd6:    level_code = 3'b101;
         default: level_code = 3'b010;
      endcase
   endfunction

   assign key_rise  = step_key & ~key_q;
   assign level_nxt = (level_idx == 3'd6) ? 3'd0 : level_idx + 3'd1;

`ifdef SNR_SWEEP_AUTO_EN
   localparam int CNT_W = $clog2(DWELL_SAMPLES + 1);
   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_SAMPLES);

   logic [CNT_W-1:0] dwell_cnt;

   assign dwell_expired = auto_mode && (dwell_cnt == DWELL_MAX);
`else
   logic unused_cfg;

   assign dwell_expired = 1'b0;
   assign unused_cfg    = auto_mode | (DWELL_SAMPLES < 1);
`endif

   // A held key edge, a pending step and a dwell expiry all collapse into one advance.
   assign advance = key_rise | step_pend | dwell_expired;

   // Combinational so the push lands in the first PUSH cycle the output FIFO has room.
   assign write_audio_out = (state == PUSH) && audio_out_allowed;
   assign busy            = (state != IDLE);

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only; the datapath latches are cleared too so an
      // abandoned sample leaves nothing behind on the corruptor or output ports.
      if (!reset_n) begin
         state         <= IDLE;
         key_q         <= 1'b0;
         step_pend     <= 1'b0;
         level_idx     <= 3'd0;
         snr_code      <= 3'b010;
         read_audio_in <= 1'b0;
         awgn_ready    <= 1'b0;
         corrupt_left  <= '0;
         corrupt_right <= '0;
         corrupt_awgn  <= '0;
         left_out      <= '0;
         right_out     <= '0;
`ifdef SNR_SWEEP_AUTO_EN
         dwell_cnt     <= '0;
`endif
      end else begin
         // NOTE: every register here uses <= so each branch sees pre-edge values (key_q vs step_key).
         key_q         <= step_key;
         read_audio_in <= 1'b0;
         if (key_rise) step_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (advance) begin
                  level_idx <= level_nxt;
                  snr_code  <= level_code(level_nxt);
                  step_pend <= 1'b0;
`ifdef SNR_SWEEP_AUTO_EN
                  dwell_cnt <= '0;
`endif
               end
               if (audio_in_available) begin
                  state         <= POP;
                  read_audio_in <= 1'b1;
               end
            end
            POP: begin
               corrupt_left  <= left_in;
               corrupt_right <= right_in;
               if (level_idx == 3'd0) begin
                  corrupt_awgn <= '0;
                  state        <= SETTLE;
               end else begin
                  awgn_ready <= 1'b1;
                  state      <= NOISE;
               end
            end
            NOISE: begin
               if (awgn_valid && awgn_ready) begin
                  corrupt_awgn <= awgn;
                  awgn_ready   <= 1'b0;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               left_out  <= noisy_left;
               right_out <= noisy_right;
               state     <= PUSH;
            end
            PUSH: begin
               if (audio_out_allowed) begin
`ifdef SNR_SWEEP_AUTO_EN
                  if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + CNT_W'(1);
`endif
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snr_sweep_ctrl.sv
// Directed bench for snr_sweep_ctrl: table of per-level samples plus backpressure, reset and dwell
// sequences. Auto-advance checks follow SNR_SWEEP_AUTO_EN.
module tb_snr_sweep_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          audio_in_available;
   logic          read_audio_in;
   logic [DW-1:0] left_in, right_in;
   logic          awgn_valid;
   logic [DW-1:0] awgn;
   logic          awgn_ready;
   logic [2:0]    snr_code;
   logic [DW-1:0] corrupt_left, corrupt_right, corrupt_awgn;
   logic [DW-1:0] noisy_left, noisy_right;
   logic          audio_out_allowed;
   logic          write_audio_out;
   logic [DW-1:0] left_out, right_out;
   logic          step_key;
   logic          auto_mode;
   logic [2:0]    level_idx;
   logic          busy;

   int total = 0;
   int bad   = 0;

   snr_sweep_ctrl #(.DATA_W(DW), .DWELL_SAMPLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .audio_in_available(audio_in_available), .read_audio_in(read_audio_in),
      .left_in(left_in), .right_in(right_in),
      .awgn_valid(awgn_valid), .awgn(awgn), .awgn_ready(awgn_ready),
      .snr_code(snr_code),
      .corrupt_left(corrupt_left), .corrupt_right(corrupt_right), .corrupt_awgn(corrupt_awgn),
      .noisy_left(noisy_left), .noisy_right(noisy_right),
      .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
      .left_out(left_out), .right_out(right_out),
      .step_key(step_key), .auto_mode(auto_mode),
      .level_idx(level_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   // Corruptor stand-in: wrap-around add of the noise word scaled down by 2^10.
   assign noisy_left  = corrupt_left + (corrupt_awgn >> 10);
   assign noisy_right = corrupt_right + (corrupt_awgn >> 10);

   typedef struct {
      int          steps;
      logic [31:0] l, r, a;
      logic [2:0]  lvl, code;
      int          lat;
      logic [31:0] el, er;
   } vec_t;

   vec_t vecs[8];

   int          s_lat, s_nready, s_nread;
   logic [31:0] s_left, s_right;
   logic [2:0]  s_code;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step_pulse();
      @(negedge clk); step_key = 1'b1;
      @(negedge clk); step_key = 1'b0;
      @(negedge clk);
   endtask

   // One sample with the noise source and output FIFO always ready; latency counts the IDLE cycle as 1.
   task automatic run_sample(input logic [31:0] l, input logic [31:0] r, input logic [31:0] a);
      int cyc;
      bit done;
      @(negedge clk);
      left_in = l; right_in = r; awgn = a;
      awgn_valid = 1'b1; audio_out_allowed = 1'b1; audio_in_available = 1'b1;
      #1;
      cyc = 1; done = 0; s_lat = -1; s_nready = 0; s_nread = 0;
      while (!done && cyc < 60) begin
         @(negedge clk); #1;
         cyc++;
         if (awgn_ready) s_nready++;
         if (read_audio_in) begin
            s_nread++;
            audio_in_available = 1'b0;
         end
         if (write_audio_out) begin
            if (read_audio_in) check("read_write_overlap", 1, 0);
            s_lat = cyc; s_left = left_out; s_right = right_out; s_code = snr_code;
            done = 1;
         end
      end
      audio_in_available = 1'b0;
      if (!done) check("write_timeout", 0, 1);
      @(negedge clk); #1;
      check("no_double_write", write_audio_out, 0);
      check("idle_after_push", busy, 0);
   endtask

   initial begin
      int nready, hs, nwrite, post, write_post, cyc;
      logic [31:0] w_left;
      logic [2:0]  w_code, w_lvl;
      bit reached;

      vecs[0] = '{0, 32'h0000_0100, 32'h0000_0200, 32'h0000_4000, 3'd0, 3'b010, 4, 32'h0000_0100, 32'h0000_0200};
      vecs[1] = '{1, 32'h0000_0100, 32'h0000_0200, 32'h0000_4000, 3'd1, 3'b001, 5, 32'h0000_0110, 32'h0000_0210};
      vecs[2] = '{1, 32'h0000_1000, 32'h0000_2000, 32'h0000_0400, 3'd2, 3'b011, 5, 32'h0000_1001, 32'h0000_2001};
      vecs[3] = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0800, 3'd3, 3'b111, 5, 32'h0000_0001, 32'h0000_0002};
      vecs[4] = '{1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FC00, 3'd4, 3'b110, 5, 32'h1274_5677, 32'h003F_FFFF};
      vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'd5, 3'b100, 5, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{1, 32'h0000_0005, 32'h0000_0007, 32'h0000_0C00, 3'd6, 3'b101, 5, 32'h0000_0008, 32'h0000_000A};
      vecs[7] = '{1, 32'hAAAA_0000, 32'h5555_0000, 32'h0000_4000, 3'd0, 3'b010, 4, 32'hAAAA_0000, 32'h5555_0000};

      reset_n = 1'b0; audio_in_available = 1'b0; left_in = '0; right_in = '0;
      awgn_valid = 1'b0; awgn = '0; audio_out_allowed = 1'b0; step_key = 1'b0; auto_mode = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      awgn_valid = 1'b1;
      @(negedge clk); #1;
      check("rst_snr_code", snr_code, 3'b010);
      check("rst_level", level_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_read", read_audio_in, 0);
      check("rst_write", write_audio_out, 0);
      check("idle_awgn_ready", awgn_ready, 0);
      check("rst_left_out", left_out, 0);

      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < vecs[i].steps; k++) step_pulse();
         check($sformatf("v%0d_level", i), level_idx, vecs[i].lvl);
         check($sformatf("v%0d_code", i), snr_code, vecs[i].code);
         run_sample(vecs[i].l, vecs[i].r, vecs[i].a);
         check($sformatf("v%0d_latency", i), s_lat, vecs[i].lat);
         check($sformatf("v%0d_left_out", i), s_left, vecs[i].el);
         check($sformatf("v%0d_right_out", i), s_right, vecs[i].er);
         check($sformatf("v%0d_write_code", i), s_code, vecs[i].code);
         check($sformatf("v%0d_ready_cycles", i), s_nready, (vecs[i].lvl == 0) ? 0 : 1);
         check($sformatf("v%0d_reads", i), s_nread, 1);
      end

      // Noise stall, two key edges while busy, then output backpressure.
      step_pulse();
      check("bp_level_before", level_idx, 1);
      @(negedge clk);
      left_in = 32'h300; right_in = 32'h400; awgn = 32'h8000;
      awgn_valid = 1'b0; audio_out_allowed = 1'b0; audio_in_available = 1'b1;
      nready = 0; hs = 0; nwrite = 0; post = 0; write_post = -1;
      w_left = '0; w_code = '0; w_lvl = '0;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         if (hs > 0) post++;
         if (post == 20) audio_out_allowed = 1'b1;
         if (nready == 10) awgn_valid = 1'b1;
         if (nready == 2 || nready == 6) step_key = 1'b1;
         if (nready == 4 || nready == 8) step_key = 1'b0;
         #1;
         if (read_audio_in) audio_in_available = 1'b0;
         if (awgn_ready) nready++;
         if (awgn_ready && awgn_valid) hs++;
         if (write_audio_out) begin
            nwrite++; write_post = post;
            w_left = left_out; w_code = snr_code; w_lvl = level_idx;
         end
      end
      awgn_valid = 1'b0;
      check("bp_ready_cycles", nready, 11);
      check("bp_handshakes", hs, 1);
      check("bp_corrupt_awgn", corrupt_awgn, 32'h8000);
      check("bp_writes", nwrite, 1);
      check("bp_write_delay", write_post, 20);
      check("bp_left_out", w_left, 32'h320);
      check("bp_write_code", w_code, 3'b001);
      check("bp_write_level", w_lvl, 1);
      check("bp_collapsed_step", level_idx, 2);
      check("bp_collapsed_code", snr_code, 3'b011);

      // Reset while stalled in NOISE abandons the sample.
      @(negedge clk);
      left_in = 32'h77; right_in = 32'h88; awgn_valid = 1'b0;
      audio_out_allowed = 1'b1; audio_in_available = 1'b1;
      reached = 0;
      for (int c = 0; c < 20 && !reached; c++) begin
         @(negedge clk); #1;
         if (read_audio_in) audio_in_available = 1'b0;
         if (awgn_ready) reached = 1;
      end
      check("rn_reached_noise", reached, 1);
      audio_in_available = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      #1;
      check("rn_busy", busy, 0);
      check("rn_awgn_ready", awgn_ready, 0);
      check("rn_level", level_idx, 0);
      check("rn_code", snr_code, 3'b010);
      check("rn_corrupt_left", corrupt_left, 0);
      check("rn_left_out", left_out, 0);
      nwrite = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (write_audio_out) nwrite++;
      end
      check("rn_no_write", nwrite, 0);

      // Dwell auto-advance: DWELL_SAMPLES=4 on this instance.
      auto_mode = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         run_sample(32'h10 * k, 32'h20 * k, 32'h0000_4000);
         @(negedge clk); @(negedge clk); #1;
`ifdef SNR_SWEEP_AUTO_EN
         check($sformatf("auto_level_%0d", k), level_idx, k / 4);
`else
         check($sformatf("auto_level_%0d", k), level_idx, 0);
`endif
      end

`ifdef SNR_SWEEP_AUTO_EN
      // Dwell saturates with auto off; key edge and expiry then coincide in one IDLE cycle.
      auto_mode = 1'b0;
      for (int k = 0; k < 5; k++) run_sample(32'h1, 32'h2, 32'h0000_4000);
      check("sat_level_held", level_idx, 2);
      @(negedge clk); auto_mode = 1'b1; step_key = 1'b1;
      @(negedge clk); step_key = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("coincide_single_step", level_idx, 3);
      check("coincide_code", snr_code, 3'b111);
`endif

      cyc = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
